// File: rtl/sched_cmd_merge_q.sv
// sched_cmd_merge_q
//
// Buffers scheduler commands from two producers and hands them, one per
// handshake, to the scheduler state-table update stage. Source 0 is the
// application data-pending path and source 1 the receive/timer path. A
// command for the same flow as the most recently written (tail) entry is
// folded into that entry, which cuts down on table write traffic.
//
// Command word layout (MSB to LSB), CMD_W = FLOWID_W + 3*(2+TS_W):
//   flowid[FLOWID_W] | rt{cmd[2],ts[TS_W]} | ack{cmd[2],ts[TS_W]} | data{cmd[2],ts[TS_W]}
//   cmd encoding: 2'd0 = NOP, 2'd1 = SET, 2'd2 = CLEAR
//
// Ports:
//   clk           in   single clock
//   rst_n         in   asynchronous active-low reset
//   src0_cmd_val  in   source 0 request valid
//   src0_cmd      in   source 0 command word
//   src0_cmd_rdy  out  source 0 accepted when high together with src0_cmd_val
//   src1_cmd_val  in   source 1 request valid
//   src1_cmd      in   source 1 command word
//   src1_cmd_rdy  out  source 1 accepted when high together with src1_cmd_val
//   sched_cmd_val out  head entry valid (registered)
//   sched_cmd     out  head entry (registered)
//   sched_cmd_rdy in   consumer takes the head
//   occupancy     out  number of valid entries
//
// DEPTH must be a power of two and at least 2.

module sched_cmd_merge_q #(
    parameter int DEPTH    = 8,
    parameter int FLOWID_W = 10,
    parameter int TS_W     = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int FIELD_W = 2 + TS_W,
    localparam int CMD_W   = FLOWID_W + 3 * FIELD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src0_cmd_val,
    input  logic [CMD_W-1:0] src0_cmd,
    output logic             src0_cmd_rdy,
    input  logic             src1_cmd_val,
    input  logic [CMD_W-1:0] src1_cmd,
    output logic             src1_cmd_rdy,
    output logic             sched_cmd_val,
    output logic [CMD_W-1:0] sched_cmd,
    input  logic             sched_cmd_rdy,
    output logic [AW:0]      occupancy
);

    localparam logic [1:0]    CMD_NOP  = 2'd0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic             r_rr;
    logic             r_out_val;
    logic [CMD_W-1:0] r_out_cmd;

    logic             w_pop;
    logic             w_win1;
    logic             w_win_val;
    logic [CMD_W-1:0] w_win_cmd;
    logic [AW-1:0]    w_tail_prev;
    logic [CMD_W-1:0] w_tail_cmd;
    logic             w_merge_hit;
    logic             w_can_accept;
    logic             w_accept;
    logic             w_alloc;
    logic [AW-1:0]    w_wr_idx;
    logic [CMD_W-1:0] w_wr_data;
    logic [CMD_W-1:0] w_merged;
    logic [AW-1:0]    w_next_head;
    logic [AW:0]      w_next_count;
    logic [CMD_W-1:0] w_next_head_data;

    // The output register mirrors "queue non-empty", so it doubles as the
    // pop qualifier; sched_cmd_rdy is ignored while empty.
    assign w_pop = r_out_val & sched_cmd_rdy;

    // Source 1 wins when it is alone or when both are valid and rr points at it.
    assign w_win1    = src1_cmd_val & (~src0_cmd_val | r_rr);
    assign w_win_val = src0_cmd_val | src1_cmd_val;
    assign w_win_cmd = w_win1 ? src1_cmd : src0_cmd;

    // Merge target is the most recently written entry. Requiring two entries
    // keeps the presented head entry out of reach of a merge.
    assign w_tail_prev  = r_tail - PTR_ONE;
    assign w_tail_cmd   = r_mem[w_tail_prev];
    assign w_merge_hit  = w_win_val & (r_count >= CNT_TWO) &
                          (w_win_cmd[CMD_W-1 -: FLOWID_W] == w_tail_cmd[CMD_W-1 -: FLOWID_W]);
    assign w_can_accept = (r_count < CNT_FULL) | w_merge_hit | w_pop;
    assign w_accept     = w_win_val & w_can_accept;
    assign w_alloc      = w_accept & ~w_merge_hit;

    // A source that is not valid still reports rdy when it would have won.
    assign src0_cmd_rdy = (~src1_cmd_val | ~r_rr) & w_can_accept;
    assign src1_cmd_rdy = (~src0_cmd_val |  r_rr) & w_can_accept;

    // Per-field merge: a non-NOP incoming field replaces the stored
    // {cmd, timestamp}; NOP fields and the flowid keep the stored value.
    always_comb begin
        w_merged = w_tail_cmd;
        for (int k = 0; k < 3; k++) begin
            if (w_win_cmd[k*FIELD_W + TS_W +: 2] != CMD_NOP) begin
                w_merged[k*FIELD_W +: FIELD_W] = w_win_cmd[k*FIELD_W +: FIELD_W];
            end
        end
    end

    assign w_wr_idx  = w_merge_hit ? w_tail_prev : r_tail;
    assign w_wr_data = w_merge_hit ? w_merged : w_win_cmd;

    // Next-state count; allocate and pop together leave it unchanged,
    // which is what makes a full queue with a pop able to take a new entry.
    always_comb begin
        w_next_count = r_count;
        if (w_alloc & ~w_pop) begin
            w_next_count = r_count + CNT_ONE;
        end else if (~w_alloc & w_pop) begin
            w_next_count = r_count - CNT_ONE;
        end
    end

    assign w_next_head = w_pop ? (r_head + PTR_ONE) : r_head;

    // The output register loads the next head entry. When that slot is being
    // written this very cycle (empty queue, or pop of the last entry, or a
    // merge into the entry about to become head) the write data is bypassed
    // so there is no bubble.
    assign w_next_head_data = (w_accept && (w_wr_idx == w_next_head)) ?
                              w_wr_data : r_mem[w_next_head];

    // Entry storage carries no reset; validity is tracked by the count only.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    // Pointers, count, round-robin state and the registered head view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rr      <= 1'b0;
            r_out_val <= 1'b0;
            r_out_cmd <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_alloc) begin
                r_tail <= r_tail + PTR_ONE;
            end
            r_count <= w_next_count;
            if (w_accept) begin
                r_rr <= ~w_win1;
            end
            r_out_val <= (w_next_count != '0);
            r_out_cmd <= (w_next_count != '0) ? w_next_head_data : '0;
        end
    end

    assign sched_cmd_val = r_out_val;
    assign sched_cmd     = r_out_cmd;
    assign occupancy     = r_count;

endmodule

// File: tb/tb_sched_cmd_merge_q.sv
// tb_sched_cmd_merge_q
//
// Scoreboard bench for sched_cmd_merge_q. A queue model of the expected
// entries is updated each time stimulus is accepted and compared against the
// DUT head whenever the consumer side is observed.

module tb_sched_cmd_merge_q;

    localparam int DEPTH    = 8;
    localparam int FLOWID_W = 10;
    localparam int TS_W     = 16;
    localparam int FIELD_W  = 2 + TS_W;
    localparam int CMD_W    = FLOWID_W + 3 * FIELD_W;
    localparam int AW       = $clog2(DEPTH);

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] SET = 2'd1;
    localparam logic [1:0] CLR = 2'd2;

    typedef logic [CMD_W-1:0] cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src0_cmd_val = 1'b0;
    cmd_t        src0_cmd = '0;
    logic        src0_cmd_rdy;
    logic        src1_cmd_val = 1'b0;
    cmd_t        src1_cmd = '0;
    logic        src1_cmd_rdy;
    logic        sched_cmd_val;
    cmd_t        sched_cmd;
    logic        sched_cmd_rdy = 1'b0;
    logic [AW:0] occupancy;

    int   totalCount = 0;
    int   badCount   = 0;
    cmd_t modelQ[$];
    logic modelRr = 1'b0;
    int   dutPopped[$];
    cmd_t dutPoppedCmds[$];
    logic lastAcc0;
    logic lastAcc1;

    sched_cmd_merge_q #(
        .DEPTH   (DEPTH),
        .FLOWID_W(FLOWID_W),
        .TS_W    (TS_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src0_cmd_val (src0_cmd_val),
        .src0_cmd     (src0_cmd),
        .src0_cmd_rdy (src0_cmd_rdy),
        .src1_cmd_val (src1_cmd_val),
        .src1_cmd     (src1_cmd),
        .src1_cmd_rdy (src1_cmd_rdy),
        .sched_cmd_val(sched_cmd_val),
        .sched_cmd    (sched_cmd),
        .sched_cmd_rdy(sched_cmd_rdy),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    // Build a command word from flowid and the three {cmd, timestamp} fields.
    function automatic cmd_t mk(input int flow, input logic [1:0] rtC, input int rtTs,
                                input logic [1:0] ackC, input int ackTs,
                                input logic [1:0] datC, input int datTs);
        cmd_t c;
        c = '0;
        c[CMD_W-1 -: FLOWID_W]            = flow[FLOWID_W-1:0];
        c[2*FIELD_W + TS_W +: 2]          = rtC;
        c[2*FIELD_W +: TS_W]              = rtTs[TS_W-1:0];
        c[FIELD_W + TS_W +: 2]            = ackC;
        c[FIELD_W +: TS_W]                = ackTs[TS_W-1:0];
        c[TS_W +: 2]                      = datC;
        c[0 +: TS_W]                      = datTs[TS_W-1:0];
        return c;
    endfunction

    function automatic int flowOf(input cmd_t c);
        return int'(c[CMD_W-1 -: FLOWID_W]);
    endfunction

    // Expected result of folding an incoming command into a stored one.
    function automatic cmd_t modelMerge(input cmd_t oldC, input cmd_t inC);
        cmd_t r;
        r = oldC;
        for (int k = 0; k < 3; k++) begin
            if (inC[k*FIELD_W + TS_W +: 2] != NOP) begin
                r[k*FIELD_W +: FIELD_W] = inC[k*FIELD_W +: FIELD_W];
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Compare the registered head view and occupancy against the model.
    task automatic sampleDut(input string tag);
        checkOutput({tag, " val"}, 64'(sched_cmd_val), 64'(modelQ.size() > 0));
        checkOutput({tag, " cmd"}, 64'(sched_cmd), (modelQ.size() > 0) ? 64'(modelQ[0]) : 64'd0);
        checkOutput({tag, " occ"}, 64'(occupancy), 64'(modelQ.size()));
    endtask

    // One cycle: drive at negedge, check rdy, step the model at posedge,
    // then check outputs just after the edge.
    task automatic applyStimulus(input logic v0, input cmd_t c0, input logic v1, input cmd_t c1,
                                 input logic crdy);
        logic win1, winv, pop, mhit, canAcc, accept;
        cmd_t wcmd;
        @(negedge clk);
        src0_cmd_val  = v0;
        src0_cmd      = c0;
        src1_cmd_val  = v1;
        src1_cmd      = c1;
        sched_cmd_rdy = crdy;
        #1;
        win1   = v1 && (!v0 || modelRr);
        winv   = v0 || v1;
        wcmd   = win1 ? c1 : c0;
        pop    = (modelQ.size() > 0) && crdy;
        mhit   = winv && (modelQ.size() >= 2) && (flowOf(wcmd) == flowOf(modelQ[$]));
        canAcc = (modelQ.size() < DEPTH) || mhit || pop;
        accept = winv && canAcc;
        checkOutput("rdy0", 64'(src0_cmd_rdy), 64'((!v1 || !modelRr) && canAcc));
        checkOutput("rdy1", 64'(src1_cmd_rdy), 64'((!v0 || modelRr) && canAcc));
        if (sched_cmd_val && crdy) begin
            dutPopped.push_back(flowOf(sched_cmd));
            dutPoppedCmds.push_back(sched_cmd);
        end
        lastAcc0 = accept && !win1;
        lastAcc1 = accept && win1;
        @(posedge clk);
        if (accept) begin
            if (mhit) modelQ[$] = modelMerge(modelQ[$], wcmd);
            else      modelQ.push_back(wcmd);
            modelRr = !win1;
        end
        if (pop) void'(modelQ.pop_front());
        #1;
        sampleDut("step");
    endtask

    task automatic idle(input logic crdy);
        applyStimulus(1'b0, '0, 1'b0, '0, crdy);
    endtask

    task automatic drainAll();
        for (int i = 0; i < 4 * DEPTH && modelQ.size() > 0; i++) begin
            idle(1'b1);
        end
        checkOutput("drain empty", 64'(occupancy), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        src0_cmd_val  = 1'b0;
        src1_cmd_val  = 1'b0;
        sched_cmd_rdy = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelQ.delete();
        modelRr = 1'b0;
        dutPopped.delete();
        dutPoppedCmds.delete();
    endtask

    initial begin
        int i0;
        int i1;
        int flows0[3];
        int flows1[3];
        int expOrder[$];

        // Reset state
        #3;
        checkOutput("reset val", 64'(sched_cmd_val), 64'd0);
        checkOutput("reset cmd", 64'(sched_cmd), 64'd0);
        checkOutput("reset occ", 64'(occupancy), 64'd0);
        checkOutput("reset rdy0", 64'(src0_cmd_rdy), 64'd1);
        checkOutput("reset rdy1", 64'(src1_cmd_rdy), 64'd1);
        doReset();

        // Single push then drain
        applyStimulus(1'b1, mk(5, NOP, 0, NOP, 0, SET, 'h21), 1'b0, '0, 1'b1);
        checkOutput("single occ1", 64'(occupancy), 64'd1);
        checkOutput("single head", 64'(sched_cmd), 64'(mk(5, NOP, 0, NOP, 0, SET, 'h21)));
        idle(1'b1);
        checkOutput("single occ0", 64'(occupancy), 64'd0);
        checkOutput("single popped", 64'(dutPopped.size() == 1 ? dutPopped[0] : -1), 64'd5);

        // Round-robin under contention with the consumer stalled
        doReset();
        flows0 = '{1, 2, 3};
        flows1 = '{11, 12, 13};
        i0 = 0;
        i1 = 0;
        for (int cyc = 0; cyc < 12 && (i0 < 3 || i1 < 3); cyc++) begin
            applyStimulus(i0 < 3, mk(i0 < 3 ? flows0[i0] : 0, NOP, 0, NOP, 0, SET, cyc),
                          i1 < 3, mk(i1 < 3 ? flows1[i1] : 0, NOP, 0, SET, cyc, NOP, 0), 1'b0);
            if (lastAcc0) i0++;
            if (lastAcc1) i1++;
        end
        checkOutput("rr occ", 64'(occupancy), 64'd6);
        drainAll();
        expOrder = '{1, 11, 2, 12, 3, 13};
        checkOutput("rr count", 64'(dutPopped.size()), 64'(expOrder.size()));
        for (int k = 0; k < expOrder.size() && k < dutPopped.size(); k++) begin
            checkOutput($sformatf("rr order %0d", k), 64'(dutPopped[k]), 64'(expOrder[k]));
        end

        // Tail merge
        doReset();
        applyStimulus(1'b1, mk(3, NOP, 0, NOP, 0, SET, 'h10), 1'b0, '0, 1'b0);
        applyStimulus(1'b1, mk(7, NOP, 0, NOP, 0, SET, 'h11), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, mk(7, NOP, 0, SET, 'h40, NOP, 0), 1'b0);
        checkOutput("merge occ", 64'(occupancy), 64'd2);
        drainAll();
        checkOutput("merge count", 64'(dutPoppedCmds.size()), 64'd2);
        if (dutPoppedCmds.size() == 2) begin
            checkOutput("merge entry2", 64'(dutPoppedCmds[1]),
                        64'(mk(7, NOP, 0, SET, 'h40, SET, 'h11)));
        end

        // Same flow twice: the head is never a merge target
        doReset();
        applyStimulus(1'b1, mk(9, NOP, 0, NOP, 0, SET, 1), 1'b0, '0, 1'b0);
        applyStimulus(1'b1, mk(9, NOP, 0, NOP, 0, CLR, 2), 1'b0, '0, 1'b0);
        checkOutput("nohead occ", 64'(occupancy), 64'd2);
        checkOutput("nohead head", 64'(sched_cmd), 64'(mk(9, NOP, 0, NOP, 0, SET, 1)));
        drainAll();
        if (dutPoppedCmds.size() == 2) begin
            checkOutput("nohead entry2", 64'(dutPoppedCmds[1]), 64'(mk(9, NOP, 0, NOP, 0, CLR, 2)));
        end else begin
            checkOutput("nohead count", 64'(dutPoppedCmds.size()), 64'd2);
        end

        // Full, push-with-pop at full, then wrap-around refill
        doReset();
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, mk(100 + k, NOP, 0, NOP, 0, SET, k), 1'b0, '0, 1'b0);
        end
        checkOutput("full occ", 64'(occupancy), 64'd8);
        applyStimulus(1'b1, mk(20, NOP, 0, NOP, 0, SET, 'h20), 1'b0, '0, 1'b0);
        checkOutput("full rdy0 held", 64'(lastAcc0), 64'd0);
        applyStimulus(1'b1, mk(20, NOP, 0, NOP, 0, SET, 'h20), 1'b0, '0, 1'b1);
        checkOutput("full push+pop acc", 64'(lastAcc0), 64'd1);
        checkOutput("full push+pop occ", 64'(occupancy), 64'd8);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, mk(21 + k, NOP, 0, NOP, 0, SET, k), 1'b0, '0, 1'b1);
        end
        drainAll();
        expOrder = '{100, 101, 102, 103, 104, 105, 106, 107, 20, 21, 22, 23};
        checkOutput("wrap count", 64'(dutPopped.size()), 64'(expOrder.size()));
        for (int k = 0; k < expOrder.size() && k < dutPopped.size(); k++) begin
            checkOutput($sformatf("wrap order %0d", k), 64'(dutPopped[k]), 64'(expOrder[k]));
        end

        // Asynchronous reset between edges with 4 entries queued
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, mk(40 + k, NOP, 0, NOP, 0, SET, k), 1'b0, '0, 1'b0);
        end
        checkOutput("areset pre occ", 64'(occupancy), 64'd4);
        @(negedge clk);
        src0_cmd_val = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset val", 64'(sched_cmd_val), 64'd0);
        checkOutput("areset occ", 64'(occupancy), 64'd0);
        checkOutput("areset cmd", 64'(sched_cmd), 64'd0);
        #1;
        rst_n = 1'b1;
        modelQ.delete();
        modelRr = 1'b0;
        idle(1'b1);
        applyStimulus(1'b1, mk(50, NOP, 0, NOP, 0, SET, 'h50), 1'b0, '0, 1'b0);
        checkOutput("areset fresh head", 64'(sched_cmd), 64'(mk(50, NOP, 0, NOP, 0, SET, 'h50)));
        checkOutput("areset fresh occ", 64'(occupancy), 64'd1);
        drainAll();

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sched_cmd_merge_q.md
# sched_cmd_merge_q

Buffers scheduler commands (`sched_cmd_struct`) from two producers and presents them one at a time to the scheduler state-table update stage. Source 0 is the application data-pending path, which emits `data_pend_set_clear.cmd = SET` with the other two fields NOP. Source 1 is the receive/timer path, which carries ack-pending and retransmit-pending set/clear. Consecutive commands for the same flow are coalesced into the queue tail, which reduces table write traffic.

## Interface
Parameters:
- `DEPTH`, default 8: queue entries; must be a power of two and at least 2.
- `FLOWID_W`, default from `tcp_pkg`: flow ID width.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `src0_cmd_val`, in, 1: source 0 request valid.
- `src0_cmd`, in, `sched_cmd_struct`: source 0 command.
- `src0_cmd_rdy`, out, 1: source 0 accepted this cycle when high together with `src0_cmd_val`.
- `src1_cmd_val`, `src1_cmd`, `src1_cmd_rdy`: same as source 0, for source 1.
- `sched_cmd_val`, out, 1: head entry valid.
- `sched_cmd`, out, `sched_cmd_struct`: head entry.
- `sched_cmd_rdy`, in, 1: consumer takes the head.
- `occupancy`, out, `$clog2(DEPTH)+1`: number of valid entries.

## Operation
- Storage is a circular buffer with head and tail pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`, plus a count register. `occupancy` equals the count.
- Arbitration:
  - One command is accepted per cycle at most.
  - Round-robin pointer `rr` resets to 0. When both sources are valid, the source equal to `rr` wins.
  - After any accept, `rr` becomes the other source, i.e. not the winner.
  - A lone valid source always wins arbitration.
- `srcN_cmd_rdy` = (source N is the winner, or source N is not valid but would win if valid) AND `can_accept`.
  - `can_accept` = (count < DEPTH) OR `merge_hit` OR `pop`.
  - `pop` = `sched_cmd_val & sched_cmd_rdy`.
- `merge_hit` = (count ≥ 2) AND (winner flowid == flowid of the tail entry, the most recently written one).
  - The head entry is never a merge target, so a presented entry stays stable.
- Merge applies per field to each of `rt_pend_set_clear`, `ack_pend_set_clear` and `data_pend_set_clear`:
  - Incoming cmd ≠ NOP: the stored {cmd, timestamp} is replaced by the incoming one.
  - Incoming cmd = NOP: the stored field is kept.
  - flowid is unchanged. The tail pointer and count do not advance.
- Allocate (accept without `merge_hit`): write the entry at the tail, then tail+1.
- Count update: count += allocate − pop. A simultaneous allocate and pop when full is legal, and count stays at `DEPTH`.
- Pop: head+1.
- Commands are never dropped or reordered, except that a merge folds a command into an earlier entry for the same flow.

## Timing
- Reset values: `sched_cmd_val` = 0, `sched_cmd` = '0, `occupancy` = 0, `rr` = 0, pointers = 0, both `srcN_cmd_rdy` = 1 (the queue is empty).
- `sched_cmd_val` and `sched_cmd` are registered views of the head entry.
  - An accept into an empty queue at edge T makes `sched_cmd_val` = 1 with that entry in the cycle after T. Latency is 1 cycle.
  - When count is 1 and the entry is popped while a new command is allocated in the same cycle, the new entry is valid on the next cycle with no bubble.
- `srcN_cmd_rdy` is combinational from `srcN_cmd_val`, `count`, the tail flowid and `sched_cmd_rdy`.
- `sched_cmd` holds stable while `sched_cmd_val & !sched_cmd_rdy`.
- Full (count = `DEPTH`), no pop, no `merge_hit`: both rdy outputs are 0, and sources hold their requests.
- Empty: `sched_cmd_val` = 0, and `sched_cmd_rdy` is ignored.
- `rst_n` asserted mid-operation: all state clears immediately (asynchronously) and queued entries are discarded. Outputs return to their reset values before the next edge.

## Test plan
- Single push, then drain:
  - Stimulus: src0 pushes flowid 5 with data SET; `sched_cmd_rdy` held at 1.
  - Required: `sched_cmd_val` is high one cycle later with flowid 5 and data SET, rt/ack NOP; `occupancy` goes 0 → 1 → 0.
- Contention round-robin:
  - Stimulus: both sources continuously valid (src0 flowids 1, 2, 3; src1 flowids 11, 12, 13); consumer stalled.
  - Required: queue order is 1, 11, 2, 12, 3, 13.
- Tail merge:
  - Stimulus: push flowid 3 (data SET), flowid 7 (data SET), then flowid 7 from src1 (ack SET, timestamp 0x40); consumer stalled.
  - Required: `occupancy` = 2, and entry 2 is flowid 7 with data SET and ack SET, timestamp 0x40.
- No merge into head:
  - Stimulus: push flowid 9, then flowid 9 again; consumer stalled.
  - Required: `occupancy` = 2, two separate entries, and head contents unchanged.
- Full and wrap-around:
  - Stimulus: with `DEPTH` = 8 fill 8 distinct flowids.
  - Required: both rdy outputs = 0.
  - Stimulus: then assert `sched_cmd_rdy` while pushing flowid 20.
  - Required: rdy is high that cycle and count stays 8. Draining then yields the original order followed by 20, across pointer wrap-around over 3 refill cycles.
- Async reset:
  - Stimulus: pulse `rst_n` low between clock edges with 4 entries queued.
  - Required: `sched_cmd_val` = 0 and `occupancy` = 0 immediately, with no stale entry after release.
